// File: rtl/pcileech_bar_cpl_pkg.sv
// Shared definitions for the BAR read completion path: reply-context field
// layout, CplD header constants and the buffered completion entry.
package pcileech_bar_cpl_pkg;

  // Reply context field layout
  localparam int CTX_RID_LSB  = 0;
  localparam int CTX_RID_W    = 16;
  localparam int CTX_TAG_LSB  = 16;
  localparam int CTX_TAG_W    = 8;
  localparam int CTX_LA_LSB   = 24;
  localparam int CTX_LA_W     = 7;
  localparam int CTX_BC_LSB   = 31;
  localparam int CTX_BC_W     = 12;
  localparam int CTX_TC_LSB   = 43;
  localparam int CTX_TC_W     = 3;
  localparam int CTX_ATTR_LSB = 46;
  localparam int CTX_ATTR_W   = 2;
  localparam int CTX_USED_W   = 48;

  // CplD header constants
  localparam logic [2:0] CPLD_FMT  = 3'b010;
  localparam logic [4:0] CPLD_TYPE = 5'b01010;
  localparam logic [9:0] CPLD_LEN  = 10'd1;

  // Completion status codes
  localparam logic [2:0] CPL_STATUS_SC  = 3'b000;
  localparam logic [2:0] CPL_STATUS_UR  = 3'b001;
  localparam logic [2:0] CPL_STATUS_CRS = 3'b010;
  localparam logic [2:0] CPL_STATUS_CA  = 3'b100;

  typedef struct packed {
    logic [CTX_TC_W-1:0]   tc;
    logic [CTX_ATTR_W-1:0] attr;
    logic [CTX_BC_W-1:0]   byte_count;
    logic [CTX_LA_W-1:0]   lower_addr;
    logic [CTX_TAG_W-1:0]  tag;
    logic [CTX_RID_W-1:0]  req_id;
    logic [31:0]           data;
  } cpl_entry_t;

  // Build the single-beat 3DW-header CplD for one buffered reply.
  function automatic logic [127:0] cpl_format(input logic [15:0] cpl_id,
                                              input cpl_entry_t e);
    logic [31:0] dw0, dw1, dw2;
    dw0 = {CPLD_FMT, CPLD_TYPE, 1'b0, e.tc, 6'b0, e.attr, 2'b0, CPLD_LEN};
    dw1 = {cpl_id, CPL_STATUS_SC, 1'b0, e.byte_count};
    dw2 = {e.req_id, e.tag, 1'b0, e.lower_addr};
    return {e.data, dw2, dw1, dw0};
  endfunction

endpackage

// File: rtl/pcileech_bar_cpl_fifo.sv
// Synchronous first-word-fall-through FIFO of completion entries with
// same-cycle push/pop; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module pcileech_bar_cpl_fifo
  import pcileech_bar_cpl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  cpl_entry_t push_entry,
  input  logic       pop,
  output cpl_entry_t pop_entry,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  cpl_entry_t    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign pop_entry = mem[rd_ptr[AW-1:0]];

  // Storage write
  // NOTE: the storage array is deliberately not reset; entries are only ever
  // read behind valid pointers, and a reset on a RAM blocks memory inference.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  // Pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pcileech_bar_cpl_tx.sv
// BAR read completion transmitter: buffers read replies, formats each into a
// single-beat CplD and presents it on the TLP stream with ready/valid.
module pcileech_bar_cpl_tx
  import pcileech_bar_cpl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  pcie_id,
  input  logic [87:0]  rd_rsp_ctx,
  input  logic [31:0]  rd_rsp_data,
  input  logic         rd_rsp_valid,
  output logic [127:0] tlp_tx_data,
  output logic [3:0]   tlp_tx_keep,
  output logic         tlp_tx_last,
  output logic         tlp_tx_valid,
  input  logic         tlp_tx_ready,
  output logic [15:0]  cpl_sent_count,
  output logic [15:0]  drop_count,
  output logic         overflow
);

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_LOADED = 1'b1;

  logic [0:0]  state;
  cpl_entry_t  push_entry;
  cpl_entry_t  pop_entry;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        accept;
  logic        drop;
  logic        unused_ctx_hi;

  assign unused_ctx_hi = ^rd_rsp_ctx[87:CTX_USED_W];

  assign push_entry.tc         = rd_rsp_ctx[CTX_TC_LSB   +: CTX_TC_W];
  assign push_entry.attr       = rd_rsp_ctx[CTX_ATTR_LSB +: CTX_ATTR_W];
  assign push_entry.byte_count = rd_rsp_ctx[CTX_BC_LSB   +: CTX_BC_W];
  assign push_entry.lower_addr = rd_rsp_ctx[CTX_LA_LSB   +: CTX_LA_W];
  assign push_entry.tag        = rd_rsp_ctx[CTX_TAG_LSB  +: CTX_TAG_W];
  assign push_entry.req_id     = rd_rsp_ctx[CTX_RID_LSB  +: CTX_RID_W];
  assign push_entry.data       = rd_rsp_data;

  assign accept = (state == ST_LOADED) && tlp_tx_ready;
  assign pop    = !fifo_empty && ((state == ST_EMPTY) || tlp_tx_ready);
  assign push   = rd_rsp_valid && (!fifo_full || pop);
  assign drop   = rd_rsp_valid && !push;

  pcileech_bar_cpl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .pop_entry  (pop_entry),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign tlp_tx_valid = (state == ST_LOADED);
  assign tlp_tx_last  = tlp_tx_valid;
  assign tlp_tx_keep  = tlp_tx_valid ? 4'hF : 4'h0;

  // Output register: load a freshly formatted beat on pop, hold it until accepted
  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_EMPTY;
      tlp_tx_data <= '0;
    end else if (pop) begin
      state       <= ST_LOADED;
      tlp_tx_data <= cpl_format(pcie_id, pop_entry);
    end else if (accept) begin
      state       <= ST_EMPTY;
    end
  end

  // Sent counter (wrapping), drop counter (saturating) and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      cpl_sent_count <= '0;
      drop_count     <= '0;
      overflow       <= 1'b0;
    end else begin
      if (accept) cpl_sent_count <= cpl_sent_count + 16'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pcileech_bar_cpl_tx.sv
// Self-checking bench for pcileech_bar_cpl_tx: directed scenarios plus a
// randomized phase, all checked against a queue-based transaction model.
module tb_pcileech_bar_cpl_tx;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  pcie_id;
  logic [87:0]  rd_rsp_ctx;
  logic [31:0]  rd_rsp_data;
  logic         rd_rsp_valid;
  logic [127:0] tlp_tx_data;
  logic [3:0]   tlp_tx_keep;
  logic         tlp_tx_last;
  logic         tlp_tx_valid;
  logic         tlp_tx_ready;
  logic [15:0]  cpl_sent_count;
  logic [15:0]  drop_count;
  logic         overflow;

  pcileech_bar_cpl_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .pcie_id        (pcie_id),
    .rd_rsp_ctx     (rd_rsp_ctx),
    .rd_rsp_data    (rd_rsp_data),
    .rd_rsp_valid   (rd_rsp_valid),
    .tlp_tx_data    (tlp_tx_data),
    .tlp_tx_keep    (tlp_tx_keep),
    .tlp_tx_last    (tlp_tx_last),
    .tlp_tx_valid   (tlp_tx_valid),
    .tlp_tx_ready   (tlp_tx_ready),
    .cpl_sent_count (cpl_sent_count),
    .drop_count     (drop_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: replies waiting in the buffer, the beat on the wire
  logic [79:0]  m_buf [$];
  logic         m_valid;
  logic [127:0] m_data;
  logic [15:0]  m_sent;
  logic [15:0]  m_drop;
  logic         m_ovf;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [87:0] mk_ctx(input int tc, input int attr, input int bc,
                                         input int la, input int tag, input int rid);
    logic [87:0] c;
    c = '0;
    c[15:0]  = rid[15:0];
    c[23:16] = tag[7:0];
    c[30:24] = la[6:0];
    c[42:31] = bc[11:0];
    c[45:43] = tc[2:0];
    c[47:46] = attr[1:0];
    return c;
  endfunction

  // Expected CplD beat computed straight from the header field definitions
  function automatic logic [127:0] exp_beat(input logic [15:0] cid, input logic [79:0] e);
    logic [31:0] dw0, dw1, dw2, dat;
    logic [47:0] c;
    c   = e[79:32];
    dat = e[31:0];
    dw0 = 32'h4A000001 | (32'(c[45:43]) << 20) | (32'(c[47:46]) << 12);
    dw1 = (32'(cid) << 16) | 32'(c[42:31]);
    dw2 = (32'(c[15:0]) << 16) | (32'(c[23:16]) << 8) | 32'(c[30:24]);
    return {dat, dw2, dw1, dw0};
  endfunction

  task automatic compare_all();
    check("valid", 128'(tlp_tx_valid), 128'(m_valid));
    check("last",  128'(tlp_tx_last),  128'(m_valid));
    check("keep",  128'(tlp_tx_keep),  m_valid ? 128'hF : 128'h0);
    if (m_valid) check("data", tlp_tx_data, m_data);
    check("sent",  128'(cpl_sent_count), 128'(m_sent));
    check("drop",  128'(drop_count),     128'(m_drop));
    check("ovf",   128'(overflow),       128'(m_ovf));
  endtask

  // One clock: drive inputs, advance the model, clock the DUT, compare
  task automatic step(input logic v, input logic [87:0] ctx, input logic [31:0] d,
                      input logic rdy);
    int  nb;
    logic accepted, popped;
    rd_rsp_valid = v;
    rd_rsp_ctx   = ctx;
    rd_rsp_data  = d;
    tlp_tx_ready = rdy;
    nb       = m_buf.size();
    accepted = m_valid && rdy;
    popped   = (nb > 0) && (!m_valid || rdy);
    if (accepted) m_sent = m_sent + 16'd1;
    if (popped) begin
      m_data  = exp_beat(pcie_id, m_buf.pop_front());
      m_valid = 1'b1;
    end else if (accepted) begin
      m_valid = 1'b0;
    end
    if (v) begin
      if (nb < DEPTH || popped) begin
        m_buf.push_back({ctx[47:0], d});
      end else begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, rdy);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    rd_rsp_valid = 1'b0;
    tlp_tx_ready = 1'b0;
    m_buf.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_sent  = '0;
    m_drop  = '0;
    m_ovf   = 1'b0;
    @(posedge clk);
    #1;
    check("rst_data", tlp_tx_data, 128'h0);
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    pcie_id      = 16'h0300;
    rd_rsp_ctx   = '0;
    rd_rsp_data  = '0;
    rd_rsp_valid = 1'b0;
    tlp_tx_ready = 1'b0;
    @(posedge clk);
    do_reset();

    // Single reply: beat appears two cycles after the strobe is driven
    step(1'b1, mk_ctx(0, 0, 4, 'h04, 'h1A, 'h0100), 32'h2620, 1'b1);
    check("single_lat1", 128'(tlp_tx_valid), 128'h0);
    step(1'b0, '0, '0, 1'b1);
    check("single_beat", tlp_tx_data, 128'h00002620_01001A04_03000004_4A000001);
    step(1'b0, '0, '0, 1'b1);
    check("single_sent", 128'(cpl_sent_count), 128'd1);

    // Backpressure: tag 1 held, then tags 1,2,3 on consecutive cycles
    for (int t = 1; t <= 3; t++)
      step(1'b1, mk_ctx(0, 0, 4, 0, t, 'h0200), 32'(t), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, '0, 1'b0);
      check("bp_hold_tag", 128'(tlp_tx_data[79:72]), 128'd1);
    end
    tlp_tx_ready = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      check("bp_order_tag", 128'(tlp_tx_data[79:72]), 128'(t));
      step(1'b0, '0, '0, 1'b1);
    end
    check("bp_drained", 128'(tlp_tx_valid), 128'h0);

    // Overflow: DEPTH+2 replies under backpressure, the last is dropped
    for (int t = 0; t < DEPTH + 2; t++)
      step(1'b1, mk_ctx(1, 1, 8, 0, 'h40 + t, 'h0300), 32'hA000 + 32'(t), 1'b0);
    check("ovf_drop", 128'(drop_count), 128'd1);
    check("ovf_flag", 128'(overflow), 128'd1);
    for (int t = 0; t < DEPTH + 1; t++) begin
      check("ovf_order_tag", 128'(tlp_tx_data[79:72]), 128'('h40 + t));
      step(1'b0, '0, '0, 1'b1);
    end
    check("ovf_sticky", 128'(overflow), 128'd1);

    // Full with same-cycle pop: pushes while full and draining are not dropped
    for (int t = 0; t < DEPTH + 1; t++)
      step(1'b1, mk_ctx(0, 0, 4, 0, 'h60 + t, 'h0400), 32'(t), 1'b0);
    for (int t = 0; t < 6; t++)
      step(1'b1, mk_ctx(0, 0, 4, 0, 'h70 + t, 'h0400), 32'(t), 1'b1);
    check("full_pop_nodrop", 128'(drop_count), 128'd1);
    idle(DEPTH + 3, 1'b1);

    // Byte count 0, TC 7, attr 3
    step(1'b1, mk_ctx(7, 3, 0, 'h7F, 'hFF, 'hFFFF), 32'hDEADBEEF, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    check("bc0_field", 128'(tlp_tx_data[43:32]), 128'h0);
    check("tc7_field", 128'(tlp_tx_data[22:20]), 128'h7);
    check("attr3_field", 128'(tlp_tx_data[13:12]), 128'h3);

    // Reset with a beat pending and more buffered
    step(1'b1, mk_ctx(0, 0, 4, 0, 'h11, 'h0500), 32'h1, 1'b0);
    do_reset();
    check("rst_valid", 128'(tlp_tx_valid), 128'h0);
    check("rst_sent", 128'(cpl_sent_count), 128'h0);
    check("rst_ovf", 128'(overflow), 128'h0);
    step(1'b1, mk_ctx(2, 1, 12, 'h08, 'h22, 'h0600), 32'h5555AAAA, 1'b1);
    check("post_rst_lat1", 128'(tlp_tx_valid), 128'h0);
    step(1'b0, '0, '0, 1'b1);
    check("post_rst_lat2", 128'(tlp_tx_valid), 128'h1);
    idle(2, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [87:0] rc;
      rc = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 31) == 0) pcie_id = 16'($urandom);
      step(($urandom_range(0, 99) < 55), rc, $urandom, ($urandom_range(0, 99) < 60));
    end
    idle(DEPTH + 3, 1'b1);
    check("rand_drained", 128'(tlp_tx_valid), 128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcileech_bar_cpl_tx.md
# pcileech_bar_cpl_tx

Completion transmitter for the BAR read path. The BAR implementation blocks return one read reply per request on `rd_rsp_ctx`/`rd_rsp_data`/`rd_rsp_valid`, with no backpressure. This block buffers those replies, formats each one into a single-beat 128-bit CplD TLP (3DW header plus 1 data DW), and drives it onto the TLP transmit stream toward the PCIe core under `ready/valid` flow control. It sits between the BAR implementation and the TX TLP mux.

## Interface
- `FIFO_DEPTH`, default 4: reply buffer entries; must be a power of two, at least 2.
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `pcie_id` in 16: completer ID (bus/dev/fn), sampled when a TLP is formatted.
- `rd_rsp_ctx` in 88: reply context. Fields are [15:0] requester ID, [23:16] tag, [30:24] lower address, [42:31] byte count, [45:43] TC, [47:46] attr. Bits [87:48] are ignored.
- `rd_rsp_data` in 32: read data DW, passed through unmodified.
- `rd_rsp_valid` in 1: single-cycle reply strobe; no ready exists upstream.
- `tlp_tx_data` out 128: TLP beat. DW0 is [31:0], DW1 is [63:32], DW2 is [95:64], data is [127:96].
- `tlp_tx_keep` out 4: per-DW enable; `4'hF` whenever valid.
- `tlp_tx_last` out 1: equals `tlp_tx_valid`, since every TLP is one beat.
- `tlp_tx_valid` out 1: beat valid.
- `tlp_tx_ready` in 1: sink accepts the beat when valid and ready are both high.
- `cpl_sent_count` out 16: completions accepted by the sink; wraps.
- `drop_count` out 16: replies lost to a full buffer; saturates at `16'hFFFF`.
- `overflow` out 1: sticky, set on the first drop, cleared only by reset.

## Operation
- **Push:** when `rd_rsp_valid` is high and the buffer is not full, or a pop happens in the same cycle, store {ctx[47:0], data}.
- **Drop:** when `rd_rsp_valid` is high, the buffer is full, and there is no same-cycle pop, discard the reply, increment `drop_count` (saturating) and set `overflow`.
- **Output register FSM:**
  - EMPTY → LOADED when the buffer is non-empty: pop one entry and format it.
  - LOADED stays LOADED while `tlp_tx_ready` is low; the beat is held stable.
  - LOADED → LOADED on accept when the buffer is non-empty: pop and format the next entry in the same cycle (back-to-back, one TLP per cycle).
  - LOADED → EMPTY on accept when the buffer is empty.
- **Formatting:**
  - DW0: fmt 3'b010, type 5'b01010, TC [22:20], attr [13:12], length 10'd1, all other bits 0.
  - DW1: completer ID [31:16], status 3'b000 [15:13], BCM 0, byte count [11:0] (0 encodes 4096).
  - DW2: requester ID [31:16], tag [15:8], bit 7 = 0, lower address [6:0].
  - DW3: `rd_rsp_data`.
- `cpl_sent_count` increments on every accepted beat and wraps from `16'hFFFF` to 0.
- Replies leave in arrival order. No reordering, no merging.

## Timing
- **Reset values:** `tlp_tx_valid`=0, `tlp_tx_last`=0, `tlp_tx_keep`=0, `tlp_tx_data`=0, `cpl_sent_count`=0, `drop_count`=0, `overflow`=0, buffer empty, FSM EMPTY.
- **Latency:** a reply with `rd_rsp_valid` at edge N, arriving at an empty block, gives `tlp_tx_valid`=1 after edge N+2. The reply is written at N and the output register loads at N+1.
- **Throughput:** one completion per cycle with `tlp_tx_ready` held high.
- **Handshake:** once `tlp_tx_valid` is asserted, `tlp_tx_data` and `tlp_tx_valid` do not change until accepted.
- **Simultaneous push and pop while full:** the push is accepted with no drop, and occupancy stays full.
- **Reset mid-operation:** the buffered and in-flight beat are discarded, and `tlp_tx_valid` is 0 from the cycle after `rst` is sampled.
- **Pointer wrap:** pointers are log2(`FIFO_DEPTH`)+1 bits. Full is declared when the MSBs differ and the rest are equal. Empty is declared when all bits are equal.

## Structure
- **Package `pcileech_bar_cpl_pkg`:**
  - ctx field offsets and widths;
  - CplD fmt/type constants;
  - completion status codes;
  - `cpl_entry_t` packed struct of {TC, attr, byte count, lower address, tag, requester ID, data}.
- **Sub-module `pcileech_bar_cpl_fifo`:** synchronous FIFO of `cpl_entry_t`, parameterised by depth, with full/empty flags and same-cycle push/pop. The top level holds the formatter, output register FSM and counters.

## Test plan
- **Single reply:**
  - Stimulus: ctx = {TC 0, attr 0, byte count 4, lower address 7'h04, tag 8'h1A, requester ID 16'h0100}, data 32'h2620, `pcie_id` 16'h0300, `tlp_tx_ready` high.
  - Response: 2 cycles later, DW0=32'h4A000001, DW1=32'h03000004, DW2=32'h01001A04, DW3=32'h00002620.
  - After the beat: `cpl_sent_count`=1.
- **Backpressure:**
  - Stimulus: `tlp_tx_ready` low, 3 replies with tags 1, 2, 3.
  - Response: beat tag 1 held stable for 10 cycles.
  - Then raise ready: tags 1, 2, 3 issue on consecutive cycles.
- **Overflow:**
  - Stimulus: ready low, `FIFO_DEPTH`+2 replies (the output register holds one more).
  - Response: `drop_count`=1, `overflow`=1, and the dropped reply is the last one.
  - Afterwards, `overflow` stays 1.
- **Full with same-cycle pop:**
  - Stimulus: buffer full, ready high, `rd_rsp_valid` high.
  - Response: no drop, and all replies emerge in order.
- **Reset mid-stream:**
  - Stimulus: `rst` high with a beat pending.
  - Response: `tlp_tx_valid` is 0 next cycle and the counters are 0.
  - A new reply afterwards emits normally with 2-cycle latency.
- **Byte count 0, TC 7, attr 2'b11:**
  - Response: DW1[11:0]=0, DW0[22:20]=3'b111, DW0[13:12]=2'b11.
